// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_arb_pkg : shared types and widths for the data-memory port arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int STREAK_W       = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR      = 2'd1,
    ST_RD_PTR  = 2'd2,
    ST_RD_DATA = 2'd3
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_port_arbiter : one SRAM op per cycle between operand fetch and write-back
// Revision 1.0
// ---------------------------------------------------------------------------
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int MAX_WR_STREAK = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_rd_req,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  input  logic                  i_rd_indirect,
  output logic                  o_rd_stall,
  output logic                  o_rd_valid,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  input  logic                  i_flush,
  input  logic                  i_wr_req,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_wr_stall,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic                  o_mem_we_n,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  localparam logic [STREAK_W-1:0] c_STREAK_MAX = STREAK_W'(MAX_WR_STREAK);

  arb_state_e            r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DATA_WIDTH-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic                  r_mem_we_n, w_mem_we_n_nxt;
  logic                  r_rd_valid, w_rd_valid_nxt;
  logic [DATA_WIDTH-1:0] r_rd_data, w_rd_data_nxt;
  logic [STREAK_W-1:0]   r_streak, w_streak_nxt;

  logic w_decide, w_rd_busy, w_rd_eligible, w_wr_grant, w_rd_grant;

  assign w_decide      = (r_state == ST_IDLE) || (r_state == ST_WR);
  assign w_rd_busy     = (r_state == ST_RD_PTR) || (r_state == ST_RD_DATA);
  // The rd_valid term forces one idle slot after each completed read.
  assign w_rd_eligible = i_rd_req & ~i_flush & ~r_rd_valid;
  assign w_wr_grant    = w_decide & i_wr_req & ((r_streak < c_STREAK_MAX) | ~w_rd_eligible);
  assign w_rd_grant    = w_decide & w_rd_eligible & ~w_wr_grant;

  assign o_rd_stall  = i_rd_req & ~(w_rd_grant | w_rd_busy);
  assign o_wr_stall  = i_wr_req & ~w_wr_grant;
  assign o_rd_valid  = r_rd_valid;
  assign o_rd_data   = r_rd_data;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_we_n  = r_mem_we_n;

  always_comb begin
    w_state_nxt     = ST_IDLE;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_we_n_nxt  = 1'b1;
    w_rd_valid_nxt  = 1'b0;
    w_rd_data_nxt   = r_rd_data;
    case (r_state)
      ST_IDLE, ST_WR: begin
        if (w_wr_grant) begin
          w_state_nxt     = ST_WR;
          w_mem_addr_nxt  = i_wr_addr;
          w_mem_wdata_nxt = i_wr_data;
          w_mem_we_n_nxt  = 1'b0;
        end else if (w_rd_grant) begin
          w_mem_addr_nxt = i_rd_addr;
          w_state_nxt    = i_rd_indirect ? ST_RD_PTR : ST_RD_DATA;
        end
      end
      ST_RD_PTR: begin
        if (!i_flush) begin
          w_mem_addr_nxt = i_mem_rdata[ADDR_WIDTH-1:0];
          w_state_nxt    = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (!i_flush) begin
          w_rd_data_nxt  = i_mem_rdata;
          w_rd_valid_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    w_streak_nxt = r_streak;
    if (!i_rd_req || w_rd_grant) begin
      w_streak_nxt = '0;
    end else if (w_wr_grant && !i_flush && (r_streak < c_STREAK_MAX)) begin
      w_streak_nxt = r_streak + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we_n  <= 1'b1;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_streak    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_we_n  <= w_mem_we_n_nxt;
      r_rd_valid  <= w_rd_valid_nxt;
      r_rd_data   <= w_rd_data_nxt;
      r_streak    <= w_streak_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dmem_port_arbiter : directed scoreboard bench with an SRAM model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rd_req, rd_indirect, flush, wr_req;
  logic [15:0] rd_addr, wr_addr, wr_data;
  logic        rd_stall, rd_valid, wr_stall, mem_we_n;
  logic [15:0] rd_data, mem_addr, mem_wdata, mem_rdata;

  logic [15:0] mem [0:65535];
  logic [15:0] rd_q [$];
  logic [31:0] wr_q [$];
  logic        mon_en = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  dmem_port_arbiter #(
    .ADDR_WIDTH(16), .DATA_WIDTH(16), .MAX_WR_STREAK(2)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr), .i_rd_indirect(rd_indirect),
    .o_rd_stall(rd_stall), .o_rd_valid(rd_valid), .o_rd_data(rd_data),
    .i_flush(flush),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_wr_stall(wr_stall),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we_n(mem_we_n),
    .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mon_en && !mem_we_n) mem[mem_addr] <= mem_wdata;
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Scoreboard monitor: pops an expectation whenever the DUT presents a read result or a write.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rd_valid === 1'b1) begin
        n_cmp++;
        if (rd_q.size() == 0) begin
          n_err++;
          $display("FAIL rd_unexpected: got rd_valid with data 0x%04h, none expected", rd_data);
        end else begin
          logic [15:0] e;
          e = rd_q.pop_front();
          if (rd_data !== e) begin
            n_err++;
            $display("FAIL rd_data: got 0x%04h expected 0x%04h", rd_data, e);
          end
        end
      end
      if (mem_we_n === 1'b0) begin
        n_cmp++;
        if (wr_q.size() == 0) begin
          n_err++;
          $display("FAIL wr_unexpected: got write 0x%04h<-0x%04h, none expected", mem_addr, mem_wdata);
        end else begin
          logic [31:0] e;
          e = wr_q.pop_front();
          if ({mem_addr, mem_wdata} !== e) begin
            n_err++;
            $display("FAIL wr_port: got 0x%04h<-0x%04h expected 0x%04h<-0x%04h",
                     mem_addr, mem_wdata, e[31:16], e[15:0]);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its end, got %0d compared", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; rd_req = 1'b0; rd_indirect = 1'b0; flush = 1'b0; wr_req = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    mem[16'h0010] = 16'hBEEF;
    mem[16'h0020] = 16'h0035;
    mem[16'h0035] = 16'h1234;
    repeat (2) step();
    neg();
    chk1 ("rst_we_n",     mem_we_n,  1'b1);
    chk16("rst_mem_addr", mem_addr,  16'h0000);
    chk16("rst_wdata",    mem_wdata, 16'h0000);
    chk1 ("rst_rd_valid", rd_valid,  1'b0);
    chk16("rst_rd_data",  rd_data,   16'h0000);
    step();
    reset_n = 1'b1; mon_en = 1'b1;

    // Direct read
    rd_req = 1'b1; rd_addr = 16'h0010; rd_indirect = 1'b0; rd_q.push_back(16'hBEEF);
    neg(); chk1("t1_rd_stall", rd_stall, 1'b0);
    step(); neg();
    chk16("t1_mem_addr", mem_addr, 16'h0010);
    chk1 ("t1_we_n",     mem_we_n, 1'b1);
    chk1 ("t1_no_early_valid", rd_valid, 1'b0);
    chk1 ("t1_stall_busy", rd_stall, 1'b0);
    step(); neg();
    chk1 ("t1_rd_valid",  rd_valid, 1'b1);
    chk1 ("t1_bubble_stall", rd_stall, 1'b1);
    step(); rd_req = 1'b0;
    neg(); chk1("t1_valid_pulse", rd_valid, 1'b0);
    step();

    // Indirect read
    rd_req = 1'b1; rd_addr = 16'h0020; rd_indirect = 1'b1; rd_q.push_back(16'h1234);
    neg(); chk1("t2_rd_stall", rd_stall, 1'b0);
    step(); neg();
    chk16("t2_ptr_addr", mem_addr, 16'h0020);
    chk1 ("t2_no_valid1", rd_valid, 1'b0);
    step(); neg();
    chk16("t2_data_addr", mem_addr, 16'h0035);
    chk1 ("t2_no_valid2", rd_valid, 1'b0);
    step(); neg();
    chk1 ("t2_rd_valid", rd_valid, 1'b1);
    step(); rd_req = 1'b0; rd_indirect = 1'b0;
    step();

    // Simultaneous read and write: write goes first
    rd_req = 1'b1; rd_addr = 16'h0010;
    wr_req = 1'b1; wr_addr = 16'h0040; wr_data = 16'hAAAA;
    wr_q.push_back({16'h0040, 16'hAAAA}); rd_q.push_back(16'hBEEF);
    neg();
    chk1("t3_rd_stall", rd_stall, 1'b1);
    chk1("t3_wr_stall", wr_stall, 1'b0);
    step(); wr_req = 1'b0;
    neg();
    chk1("t3_we_n_wr", mem_we_n, 1'b0);
    chk1("t3_rd_granted", rd_stall, 1'b0);
    step(); neg();
    chk16("t3_rd_addr", mem_addr, 16'h0010);
    chk1 ("t3_we_n_rd", mem_we_n, 1'b1);
    chk16("t3_mem040", mem[16'h0040], 16'hAAAA);
    step(); neg();
    chk1 ("t3_rd_valid", rd_valid, 1'b1);
    step(); rd_req = 1'b0;
    step();

    // Write streak limit with a read waiting
    rd_req = 1'b1; rd_addr = 16'h0035; rd_q.push_back(16'h1234);
    wr_req = 1'b1; wr_addr = 16'h0060; wr_data = 16'h6000;
    wr_q.push_back({16'h0060, 16'h6000});
    wr_q.push_back({16'h0061, 16'h6001});
    wr_q.push_back({16'h0062, 16'h6002});
    neg();
    chk1("t4_wr0_stall", wr_stall, 1'b0);
    chk1("t4_rd0_stall", rd_stall, 1'b1);
    step(); wr_addr = 16'h0061; wr_data = 16'h6001;
    neg();
    chk1("t4_wr1_stall", wr_stall, 1'b0);
    chk1("t4_rd1_stall", rd_stall, 1'b1);
    step(); wr_addr = 16'h0062; wr_data = 16'h6002;
    neg();
    chk1("t4_wr_stall_grant", wr_stall, 1'b1);
    chk1("t4_rd_granted",     rd_stall, 1'b0);
    step(); neg();
    chk1 ("t4_wr_stall_rddata", wr_stall, 1'b1);
    chk16("t4_rd_addr", mem_addr, 16'h0035);
    step(); neg();
    chk1("t4_rd_valid",   rd_valid, 1'b1);
    chk1("t4_wr_resumes", wr_stall, 1'b0);
    step(); rd_req = 1'b0; wr_req = 1'b0;
    neg();
    chk1 ("t4_we_n_resume", mem_we_n, 1'b0);
    chk16("t4_addr_resume", mem_addr, 16'h0062);
    step();

    // Flush while fetching the pointer of an indirect read
    rd_req = 1'b1; rd_addr = 16'h0020; rd_indirect = 1'b1;
    neg(); chk1("t5_rd_stall", rd_stall, 1'b0);
    step();
    rd_req = 1'b0; flush = 1'b1;
    wr_req = 1'b1; wr_addr = 16'h0070; wr_data = 16'h7777;
    wr_q.push_back({16'h0070, 16'h7777});
    neg();
    chk1 ("t5_wr_stall_ptr", wr_stall, 1'b1);
    chk16("t5_ptr_addr", mem_addr, 16'h0020);
    step(); flush = 1'b0; rd_indirect = 1'b0;
    neg();
    chk16("t5_no_second_addr", mem_addr, 16'h0020);
    chk1 ("t5_we_n_idle", mem_we_n, 1'b1);
    chk1 ("t5_wr_granted", wr_stall, 1'b0);
    step(); wr_req = 1'b0;
    neg();
    chk1("t5_we_n_wr",  mem_we_n, 1'b0);
    chk1("t5_no_valid", rd_valid, 1'b0);
    step(); neg();
    chk1("t5_no_valid_late", rd_valid, 1'b0);
    step();

    // Reset asserted during a write cycle
    wr_req = 1'b1; wr_addr = 16'h0050; wr_data = 16'h5555;
    wr_q.push_back({16'h0050, 16'h5555});
    neg(); chk1("t6_wr_stall", wr_stall, 1'b0);
    step(); wr_req = 1'b0; reset_n = 1'b0;
    neg(); chk1("t6_we_n_wr", mem_we_n, 1'b0);
    step(); reset_n = 1'b1;
    neg();
    chk1 ("t6_rst_we_n",  mem_we_n,  1'b1);
    chk16("t6_rst_addr",  mem_addr,  16'h0000);
    chk16("t6_rst_wdata", mem_wdata, 16'h0000);
    chk1 ("t6_rst_valid", rd_valid,  1'b0);
    chk16("t6_rst_rdata", rd_data,   16'h0000);
    chk16("t6_mem050",    mem[16'h0050], 16'h5555);
    step();
    rd_req = 1'b1; rd_addr = 16'h0050; rd_q.push_back(16'h5555);
    neg(); chk1("t6_rd_stall", rd_stall, 1'b0);
    step(); neg();
    chk16("t6_rd_addr", mem_addr, 16'h0050);
    step(); neg();
    chk1("t6_rd_valid", rd_valid, 1'b1);
    step(); rd_req = 1'b0;
    repeat (3) step();

    chk16("rd_q_drained", 16'(rd_q.size()), 16'd0);
    chk16("wr_q_drained", 16'(wr_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
